// File: rtl/modbus_rtu_frame_rx_if.sv
// Modbus RTU frame receiver bus interface.
// Bundles the UART-side byte stream and station address (driven by the
// master) with the forwarded payload stream and per-frame status (driven
// by the receiver, which connects through the slave modport).
//   rx_data_i/rx_valid_i/rx_err_i : received byte, strobe, UART error flag
//   my_addr_i                     : station address (quasi-static)
//   pay_data_o/pay_valid_o        : forwarded frame bytes, CRC stripped
//   frame_start_o/frame_done_o    : frame boundary pulses
//   frame_ok_o/crc_err_o/addr_match_o/len_o : status, valid at frame_done_o
//   busy_o                        : a frame is being received or discarded
interface modbus_rtu_frame_rx_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_err_i;
  logic [7:0] my_addr_i;
  logic [7:0] pay_data_o;
  logic       pay_valid_o;
  logic       frame_start_o;
  logic       frame_done_o;
  logic       frame_ok_o;
  logic       crc_err_o;
  logic       addr_match_o;
  logic [8:0] len_o;
  logic       busy_o;

  modport master (
    output rx_data_i, rx_valid_i, rx_err_i, my_addr_i,
    input  pay_data_o, pay_valid_o, frame_start_o, frame_done_o,
           frame_ok_o, crc_err_o, addr_match_o, len_o, busy_o
  );

  modport slave (
    input  rx_data_i, rx_valid_i, rx_err_i, my_addr_i,
    output pay_data_o, pay_valid_o, frame_start_o, frame_done_o,
           frame_ok_o, crc_err_o, addr_match_o, len_o, busy_o
  );
endinterface

// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU frame receiver.
// Delimits frames by line silence (t3.5 ends a frame, a gap over t1.5 inside
// a frame invalidates it), checks the CRC16 residue, station address, length
// and UART errors, and forwards address + PDU bytes with the CRC stripped.
// Ports:
//   clk   : single clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   bus   : modbus_rtu_frame_rx_if.slave (byte input, payload and status out)
module modbus_rtu_frame_rx #(
  parameter int T35_TICKS = 3500,
  parameter int T15_TICKS = 1500,
  parameter int MAX_LEN   = 256
) (
  input logic                   clk,
  input logic                   rst_n,
  modbus_rtu_frame_rx_if.slave  bus
);

  localparam int             CW      = $clog2(T35_TICKS + 1);
  localparam logic [CW-1:0]  T35_C   = CW'(T35_TICKS);
  localparam logic [CW-1:0]  T35_M1  = CW'(T35_TICKS - 1);
  localparam logic [CW-1:0]  T15_C   = CW'(T15_TICKS);
  localparam logic [8:0]     LEN_MAX = 9'(MAX_LEN);
  localparam logic [8:0]     LEN_SAT = 9'(MAX_LEN + 1);

  typedef enum logic [1:0] {SYNC, IDLE, RECV, DISCARD} state_t;

  state_t        state;
  logic [CW-1:0] silence;
  logic [15:0]   crc;
  logic [8:0]    len;
  logic [7:0]    d0;
  logic [7:0]    d1;
  logic          addr_hit;
  logic          err_seen;

  logic          silence_done;
  logic [8:0]    len_inc;
  logic          good;

  // Modbus CRC16, reflected poly 0xA001, one byte LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  // The silence counter reaches T35 on the edge where it is at T35-1 with no
  // byte arriving; acting on that edge puts frame_done_o T35+1 cycles after
  // the last strobe and leaves the state IDLE during the done cycle.
  assign silence_done = !bus.rx_valid_i && (silence == T35_M1);
  assign len_inc      = (len == LEN_SAT) ? len : len + 9'd1;
  assign good         = (crc == 16'h0000) && addr_hit && (len >= 9'd4) &&
                        (len <= LEN_MAX) && !err_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= SYNC;
      silence           <= '0;
      crc               <= 16'hFFFF;
      len               <= '0;
      d0                <= '0;
      d1                <= '0;
      addr_hit          <= 1'b0;
      err_seen          <= 1'b0;
      bus.pay_data_o    <= 8'h00;
      bus.pay_valid_o   <= 1'b0;
      bus.frame_start_o <= 1'b0;
      bus.frame_done_o  <= 1'b0;
      bus.frame_ok_o    <= 1'b0;
      bus.crc_err_o     <= 1'b0;
      bus.addr_match_o  <= 1'b0;
      bus.len_o         <= '0;
      bus.busy_o        <= 1'b0;
    end else begin
      bus.pay_valid_o   <= 1'b0;
      bus.frame_start_o <= 1'b0;
      bus.frame_done_o  <= 1'b0;

      if (bus.rx_valid_i) begin
        silence <= '0;
      end else if (silence != T35_C) begin
        silence <= silence + 1'b1;
      end

      case (state)
        SYNC: begin
          if (silence_done) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          if (bus.rx_valid_i) begin
            state             <= RECV;
            bus.busy_o        <= 1'b1;
            bus.frame_start_o <= 1'b1;
            crc               <= crc16_byte(16'hFFFF, bus.rx_data_i);
            len               <= 9'd1;
            d0                <= bus.rx_data_i;
            addr_hit          <= (bus.rx_data_i == bus.my_addr_i) ||
                                 (bus.rx_data_i == 8'h00);
            err_seen          <= bus.rx_err_i;
          end
        end

        RECV: begin
          if (bus.rx_valid_i) begin
            len <= len_inc;
            if (silence > T15_C) begin
              state <= DISCARD;
            end else begin
              crc      <= crc16_byte(crc, bus.rx_data_i);
              d0       <= bus.rx_data_i;
              d1       <= d0;
              err_seen <= err_seen | bus.rx_err_i;
              // Byte n releases byte n-2, so the trailing CRC pair never leaves.
              if (len >= 9'd2 && len < LEN_MAX) begin
                bus.pay_data_o  <= d1;
                bus.pay_valid_o <= 1'b1;
              end
            end
          end else if (silence_done) begin
            state            <= IDLE;
            bus.busy_o       <= 1'b0;
            bus.frame_done_o <= 1'b1;
            bus.frame_ok_o   <= good;
            bus.crc_err_o    <= (crc != 16'h0000);
            bus.addr_match_o <= addr_hit;
            bus.len_o        <= len;
          end
        end

        DISCARD: begin
          if (bus.rx_valid_i) begin
            len <= len_inc;
          end else if (silence_done) begin
            state            <= IDLE;
            bus.busy_o       <= 1'b0;
            bus.frame_done_o <= 1'b1;
            bus.frame_ok_o   <= 1'b0;
            bus.crc_err_o    <= (crc != 16'h0000);
            bus.addr_match_o <= addr_hit;
            bus.len_o        <= len;
          end
        end

        default: begin
          state <= SYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_rtu_frame_rx.sv
// Self-checking bench for modbus_rtu_frame_rx.
// A table of frames with expected status is applied in a loop; payload bytes,
// frame starts and frame results go into scoreboard queues when driven and
// are popped by a negedge monitor when the receiver produces them. A few
// hand-written sequences cover reset, SYNC and back-to-back framing.
module tb_modbus_rtu_frame_rx;

  localparam int T35  = 200;
  localparam int T15  = 120;
  localparam int MAXL = 8;
  localparam int NVEC = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  modbus_rtu_frame_rx_if bus();

  modbus_rtu_frame_rx #(
    .T35_TICKS(T35),
    .T15_TICKS(T15),
    .MAX_LEN  (MAXL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [7:0]      addr;
    int              n;
    logic [9:0][7:0] b;
    int              err_idx;
    int              gap_idx;
    int              end_gap;
    logic            e_ok;
    logic            e_crc;
    logic            e_am;
    logic [8:0]      e_len;
    logic            detail;
  } vec_t;

  typedef struct {
    logic       ok;
    logic       crc;
    logic       am;
    logic [8:0] len;
    logic       detail;
    int         cyc;
  } frame_exp_t;

  vec_t       vecs [NVEC];
  logic [7:0] bl   [10];
  frame_exp_t fq [$];
  logic [7:0] pq [$];
  int         sq [$];

  // Bit-serial reference CRC: shifts one data bit at a time into the LFSR.
  function automatic logic [15:0] refCrc(input logic [9:0][7:0] b, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  function automatic vec_t mkVec(input logic [7:0] addr, input int n,
                                 input logic [7:0] src [10], input logic add_crc,
                                 input int err_idx, input int gap_idx,
                                 input int end_gap, input logic e_ok,
                                 input logic e_crc, input logic e_am,
                                 input int e_len, input logic detail);
    vec_t        v;
    logic [15:0] c;
    v.addr = addr;
    v.n    = n;
    for (int i = 0; i < 10; i++) v.b[i] = src[i];
    if (add_crc) begin
      c          = refCrc(v.b, n - 2);
      v.b[n - 2] = c[7:0];
      v.b[n - 1] = c[15:8];
    end
    v.err_idx = err_idx;
    v.gap_idx = gap_idx;
    v.end_gap = end_gap;
    v.e_ok    = e_ok;
    v.e_crc   = e_crc;
    v.e_am    = e_am;
    v.e_len   = 9'(e_len);
    v.detail  = detail;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: got an unexpected pulse, expected none", name);
  endtask

  // Drives one byte for one cycle, then idles so the next strobe is gap cycles later.
  task automatic sendByte(input logic [7:0] d, input logic err, input int gap);
    bus.rx_data_i  = d;
    bus.rx_err_i   = err;
    bus.rx_valid_i = 1'b1;
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
    bus.rx_err_i   = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic       disc;
    int         g;
    frame_exp_t fr;
    bus.my_addr_i = v.addr;
    disc = 1'b0;
    for (int n = 0; n < v.n; n++) begin
      if (n == v.gap_idx) disc = 1'b1;
      if (n == 0) sq.push_back(cyc + 1);
      if (!disc && n >= 2 && n < MAXL) pq.push_back(v.b[n - 2]);
      if (n == v.n - 1) begin
        fr.ok     = v.e_ok;
        fr.crc    = v.e_crc;
        fr.am     = v.e_am;
        fr.len    = v.e_len;
        fr.detail = v.detail;
        fr.cyc    = cyc + T35 + 1;
        fq.push_back(fr);
        g = v.end_gap;
      end else begin
        g = (n + 1 == v.gap_idx) ? T15 + 10 : 100;
      end
      sendByte(v.b[n], (n == v.err_idx), g);
    end
    if (v.end_gap > T35 + 1) begin
      checkOutput("hold_ok", {31'd0, bus.frame_ok_o}, {31'd0, v.e_ok});
      if (v.detail) checkOutput("hold_len", {23'd0, bus.len_o}, {23'd0, v.e_len});
    end
  endtask

  // Monitor: every output event must match the head of its scoreboard queue.
  always @(negedge clk) begin : mon
    frame_exp_t fe;
    logic [7:0] pe;
    int         se;
    if (rst_n === 1'b1) begin
      if (bus.pay_valid_o) begin
        if (pq.size() == 0) unexpected("pay_valid");
        else begin
          pe = pq.pop_front();
          checkOutput("pay_data", {24'd0, bus.pay_data_o}, {24'd0, pe});
        end
      end
      if (bus.frame_start_o) begin
        if (sq.size() == 0) unexpected("frame_start");
        else begin
          se = sq.pop_front();
          checkOutput("start_cycle", cyc, se);
        end
      end
      if (bus.frame_done_o) begin
        if (fq.size() == 0) unexpected("frame_done");
        else begin
          fe = fq.pop_front();
          checkOutput("done_cycle", cyc, fe.cyc);
          checkOutput("frame_ok", {31'd0, bus.frame_ok_o}, {31'd0, fe.ok});
          if (fe.detail) begin
            checkOutput("crc_err", {31'd0, bus.crc_err_o}, {31'd0, fe.crc});
            checkOutput("addr_match", {31'd0, bus.addr_match_o}, {31'd0, fe.am});
            checkOutput("len", {23'd0, bus.len_o}, {23'd0, fe.len});
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b0;
    bus.rx_err_i   = 1'b0;
    bus.my_addr_i  = 8'h01;

    bl = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A, 8'h00, 8'h00};
    vecs[0] = mkVec(8'h01, 8, bl, 1'b0, -1, -1, T35 + 20, 1'b1, 1'b0, 1'b1, 8, 1'b1);
    vecs[2] = mkVec(8'h02, 8, bl, 1'b0, -1, -1, T35 + 20, 1'b0, 1'b0, 1'b0, 8, 1'b1);
    vecs[4] = mkVec(8'h01, 8, bl, 1'b0, -1,  4, T35 + 20, 1'b0, 1'b0, 1'b1, 8, 1'b0);
    vecs[6] = mkVec(8'h01, 8, bl, 1'b0,  2, -1, T35 + 20, 1'b0, 1'b0, 1'b1, 8, 1'b1);
    bl[7] = 8'h0B;
    vecs[1] = mkVec(8'h01, 8, bl, 1'b0, -1, -1, T35 + 20, 1'b0, 1'b1, 1'b1, 8, 1'b1);
    bl = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3] = mkVec(8'h02, 8, bl, 1'b1, -1, -1, T35 + 20, 1'b1, 1'b0, 1'b1, 8, 1'b1);
    bl = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[5] = mkVec(8'h01, 3, bl, 1'b1, -1, -1, T35 + 20, 1'b0, 1'b0, 1'b1, 3, 1'b1);
    bl = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[7] = mkVec(8'h01, 4, bl, 1'b1, -1, -1, T35 + 1, 1'b1, 1'b0, 1'b1, 4, 1'b1);
    bl = '{8'h01, 8'h06, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[8] = mkVec(8'h01, 8, bl, 1'b1, -1, -1, T35 + 20, 1'b1, 1'b0, 1'b1, 8, 1'b1);
    bl = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00};
    vecs[9] = mkVec(8'h01, 9, bl, 1'b1, -1, -1, T35 + 20, 1'b0, 1'b0, 1'b1, 9, 1'b1);

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_pay_valid", {31'd0, bus.pay_valid_o}, 32'd0);
    checkOutput("rst_pay_data", {24'd0, bus.pay_data_o}, 32'd0);
    checkOutput("rst_frame_done", {31'd0, bus.frame_done_o}, 32'd0);
    checkOutput("rst_len", {23'd0, bus.len_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("sync_busy", {31'd0, bus.busy_o}, 32'd0);
    repeat (T35 + 10) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      $display("[TB] applying vector %0d", i);
      applyStimulus(vecs[i]);
    end

    // Reset after four bytes of a frame: no frame_done, then SYNC again.
    $display("[TB] reset mid-frame");
    bus.my_addr_i = 8'h01;
    sq.push_back(cyc + 1);
    sendByte(8'h01, 1'b0, 100);
    sendByte(8'h03, 1'b0, 100);
    checkOutput("busy_recv", {31'd0, bus.busy_o}, 32'd1);
    pq.push_back(8'h01);
    sendByte(8'h00, 1'b0, 100);
    pq.push_back(8'h03);
    sendByte(8'h00, 1'b0, 100);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", {31'd0, bus.busy_o}, 32'd0);
    checkOutput("async_rst_len", {23'd0, bus.len_o}, 32'd0);
    checkOutput("async_rst_pay_data", {24'd0, bus.pay_data_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) sendByte(8'h01, 1'b0, 50);
    checkOutput("sync_ignore_busy", {31'd0, bus.busy_o}, 32'd0);
    repeat (T35 + 10) @(negedge clk);
    applyStimulus(vecs[0]);

    for (int i = 0; i < 2 * T35 && (fq.size() != 0 || pq.size() != 0); i++)
      @(negedge clk);
    checkOutput("frames_pending", fq.size(), 32'd0);
    checkOutput("payload_pending", pq.size(), 32'd0);
    checkOutput("starts_pending", sq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/modbus_rtu_frame_rx.md
MODBUS_RTU_FRAME_RX -- requirements
Module: modbus_rtu_frame_rx

Interface
REQ-001 SHALL have parameter T35_TICKS, default 3500: clk cycles of line silence that end a frame (t3.5).
REQ-002 SHALL have parameter T15_TICKS, default 1500: clk cycles of silence beyond which a mid-frame gap is illegal (t1.5); T15_TICKS < T35_TICKS.
REQ-003 SHALL have parameter MAX_LEN, default 256: max frame bytes, address and CRC included.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 rx_data_i  in  8  received byte from UART.
REQ-007 rx_valid_i  in  1  one-cycle strobe qualifying rx_data_i.
REQ-008 rx_err_i  in  1  UART framing/parity error for the byte strobed this cycle.
REQ-009 my_addr_i  in  8  station address; quasi-static.
REQ-010 pay_data_o  out  8  forwarded frame byte (address + PDU, CRC stripped).
REQ-011 pay_valid_o  out  1  one-cycle strobe qualifying pay_data_o.
REQ-012 frame_start_o  out  1  one-cycle pulse on first byte of an accepted frame.
REQ-013 frame_done_o  out  1  one-cycle pulse at end of frame; status outputs valid this cycle.
REQ-014 frame_ok_o  out  1  frame good: CRC, length, gap, UART and address checks all pass.
REQ-015 crc_err_o  out  1  CRC residue nonzero.
REQ-016 addr_match_o  out  1  byte 0 equals my_addr_i or 0x00 (broadcast).
REQ-017 len_o  out  9  total bytes received in frame, saturating at MAX_LEN+1.
REQ-018 busy_o  out  1  high in states RECV and DISCARD.

Function
REQ-019 SHALL keep a silence counter: cleared on any cycle with rx_valid_i, else incremented, saturating at T35_TICKS.
REQ-020 SHALL implement states SYNC, IDLE, RECV, DISCARD; SYNC after reset, SYNC->IDLE when counter reaches T35_TICKS; bytes in SYNC ignored (counter cleared).
REQ-021 IDLE + rx_valid_i -> RECV; byte is frame byte 0; frame_start_o pulses next cycle.
REQ-022 RECV + rx_valid_i with counter > T15_TICKS -> DISCARD (gap violation).
REQ-023 RECV with counter reaching T35_TICKS -> IDLE with frame_done_o pulse T35_TICKS+1 cycles after the last byte's rx_valid_i cycle.
REQ-024 DISCARD swallows bytes, emits nothing; -> IDLE on T35_TICKS silence with frame_done_o pulse, frame_ok_o=0.
REQ-025 SHALL compute Modbus CRC16 (poly 0xA001 reflected, init 0xFFFF, LSB-first) over every frame byte, one byte per rx_valid_i, CRC bytes included; crc_err_o = (residue != 0x0000).
REQ-026 SHALL hold the two most recent bytes in a delay line; on byte n>=2, pay_data_o = byte n-2 with pay_valid_o one cycle after rx_valid_i; last two bytes (CRC) never forwarded.
REQ-027 frame_ok_o = !crc_err && addr_match && len in [4,MAX_LEN] && no rx_err_i seen && no gap violation.
REQ-028 Frames with len > MAX_LEN: forwarding stops, frame_ok_o=0, len_o=MAX_LEN+1.
REQ-029 Status outputs SHALL hold from frame_done_o until next frame_start_o.
REQ-030 rx_valid_i in the same cycle as frame_done_o SHALL start a new frame (state is IDLE at that edge).
REQ-031 rx_err_i SHALL not stop reception; it only forces frame_ok_o=0.

Reset
REQ-032 rst_n low SHALL asynchronously force: state SYNC, counter 0, CRC 0xFFFF, len 0, all outputs 0 (pay_data_o 0x00, len_o 0).
REQ-033 Reset mid-frame SHALL abort without frame_done_o; reception resumes only after a full T35_TICKS silence.

Verification
REQ-034 After SYNC, my_addr_i=0x01, bytes 01 03 00 00 00 01 84 0A, gaps 100 cycles -> payload 01 03 00 00 00 01, frame_done_o with frame_ok_o=1, crc_err_o=0, addr_match_o=1, len_o=8.
REQ-035 Same frame, last byte 0x0B -> frame_ok_o=0, crc_err_o=1, len_o=8.
REQ-036 my_addr_i=0x02, frame of REQ-034 -> addr_match_o=0, crc_err_o=0, frame_ok_o=0; byte 0 changed to 00 with valid CRC -> addr_match_o=1.
REQ-037 Gap of T15_TICKS+10 cycles after byte 3 -> no further pay_valid_o, frame_done_o with frame_ok_o=0.
REQ-038 Three-byte frame -> frame_ok_o=0, len_o=3, one payload byte; rx_err_i on byte 2 of a valid frame -> frame_ok_o=0.
REQ-039 rst_n low after byte 4 -> no frame_done_o; bytes within T35_TICKS after release ignored.
